riscv32f_csr_unit: RTL and testbench

RISCV32F_CSR_UNIT -- requirements
Module: riscv32f_csr_unit

---
 rtl/riscv32f_pkg.sv | 40 ++++
 rtl/riscv32f_csr_unit.sv | 141 ++++++++++++++
 tb/tb_riscv32f_csr_unit.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/riscv32f_pkg.sv
// Shared RV32F definitions: FP CSR numbers, rounding-mode encodings, exception flag layout.
package riscv32f_pkg;

    localparam logic [11:0] CSR_FFLAGS = 12'h001;
    localparam logic [11:0] CSR_FRM    = 12'h002;
    localparam logic [11:0] CSR_FCSR   = 12'h003;

    localparam logic [2:0] RM_RNE = 3'b000;
    localparam logic [2:0] RM_RTZ = 3'b001;
    localparam logic [2:0] RM_RDN = 3'b010;
    localparam logic [2:0] RM_RUP = 3'b011;
    localparam logic [2:0] RM_RMM = 3'b100;
    localparam logic [2:0] RM_DYN = 3'b111;

    localparam int FLAG_NX = 0;
    localparam int FLAG_UF = 1;
    localparam int FLAG_OF = 2;
    localparam int FLAG_DZ = 3;
    localparam int FLAG_NV = 4;

    typedef enum logic [1:0] {
        CSR_OP_WRITE = 2'b00,
        CSR_OP_SET   = 2'b01,
        CSR_OP_CLEAR = 2'b10,
        CSR_OP_READ  = 2'b11
    } riscv32f_csr_op_t;

    typedef struct packed {
        logic nv;
        logic dz;
        logic of;
        logic uf;
        logic nx;
    } riscv32f_fflags_t;

    function automatic logic rm_is_reserved(input logic [2:0] rm);
        return (rm == 3'b101) || (rm == 3'b110) || (rm == 3'b111);
    endfunction

endpackage

// File: rtl/riscv32f_csr_unit.sv
// FP CSR unit: holds fflags/frm, serves FFLAGS/FRM/FCSR accesses over a valid/ready
// request/response pair and accumulates FPU exception flags.
module riscv32f_csr_unit
    import riscv32f_pkg::*;
#(
    parameter logic [2:0] RESET_FRM = RM_RNE
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        csr_req_valid,
    output logic        csr_req_ready,
    input  logic [11:0] csr_req_addr,
    input  logic [1:0]  csr_req_op,
    input  logic [31:0] csr_req_data,
    output logic        csr_resp_valid,
    input  logic        csr_resp_ready,
    output logic [31:0] csr_resp_data,
    output logic        csr_resp_error,
    input  logic        fpu_flags_valid,
    input  logic [4:0]  fpu_flags,
    input  logic [2:0]  inst_rm,
    output logic [2:0]  eff_rm,
    output logic        eff_rm_illegal,
    output logic [4:0]  fflags,
    output logic [2:0]  frm
);

    typedef enum logic {S_IDLE, S_RESP} state_t;

    state_t           state;
    riscv32f_fflags_t fflags_q;
    riscv32f_fflags_t fflags_next;
    logic [2:0]       frm_q;
    logic [2:0]       frm_next;

    logic             accept;
    logic             hit_fflags;
    logic             hit_frm;
    logic             hit_fcsr;
    logic             addr_ok;
    logic [7:0]       mask;
    logic [7:0]       old_val;
    logic [7:0]       operand;
    logic [7:0]       new_val;
    riscv32f_csr_op_t op;
    logic             req_data_unused;

    function automatic logic [7:0] csr_apply(input riscv32f_csr_op_t op_i,
                                             input logic [7:0] old_i,
                                             input logic [7:0] opnd_i);
        logic [7:0] res;
        unique case (op_i)
            CSR_OP_WRITE: res = opnd_i;
            CSR_OP_SET:   res = old_i | opnd_i;
            CSR_OP_CLEAR: res = old_i & ~opnd_i;
            default:      res = old_i;
        endcase
        return res;
    endfunction

    assign csr_req_ready   = (state == S_IDLE) | csr_resp_ready;
    assign accept          = csr_req_valid & csr_req_ready;
    assign op              = riscv32f_csr_op_t'(csr_req_op);
    assign req_data_unused = ^csr_req_data[31:8];

    assign hit_fflags = (csr_req_addr == CSR_FFLAGS);
    assign hit_frm    = (csr_req_addr == CSR_FRM);
    assign hit_fcsr   = (csr_req_addr == CSR_FCSR);
    assign addr_ok    = hit_fflags | hit_frm | hit_fcsr;

    // Work in an 8-bit FCSR-shaped view; the mask zero-extends narrower CSRs
    // and leaves old_val at zero for unknown addresses.
    always_comb begin
        mask    = 8'h00;
        old_val = 8'h00;
        if (hit_fflags) begin
            mask    = 8'h1F;
            old_val = {3'b000, fflags_q};
        end else if (hit_frm) begin
            mask    = 8'h07;
            old_val = {5'b00000, frm_q};
        end else if (hit_fcsr) begin
            mask    = 8'hFF;
            old_val = {frm_q, fflags_q};
        end
        operand = csr_req_data[7:0] & mask;
        new_val = csr_apply(op, old_val, operand) & mask;
    end

    // FPU flags are OR-ed on top of any CSR result so a coincident report is never lost.
    always_comb begin
        fflags_next = fflags_q;
        frm_next    = frm_q;
        if (accept) begin
            if (hit_fflags || hit_fcsr) fflags_next = riscv32f_fflags_t'(new_val[4:0]);
            if (hit_frm)                frm_next    = new_val[2:0];
            if (hit_fcsr)               frm_next    = new_val[7:5];
        end
        if (fpu_flags_valid) fflags_next = riscv32f_fflags_t'(fflags_next | fpu_flags);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= S_IDLE;
            csr_resp_valid <= 1'b0;
            csr_resp_data  <= 32'h0;
            csr_resp_error <= 1'b0;
            fflags_q       <= '0;
            frm_q          <= RESET_FRM;
        end else begin
            fflags_q <= fflags_next;
            frm_q    <= frm_next;
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        state          <= S_RESP;
                        csr_resp_valid <= 1'b1;
                        csr_resp_data  <= {24'h0, old_val};
                        csr_resp_error <= ~addr_ok;
                    end
                end
                S_RESP: begin
                    if (accept) begin
                        csr_resp_data  <= {24'h0, old_val};
                        csr_resp_error <= ~addr_ok;
                    end else if (csr_resp_ready) begin
                        state          <= S_IDLE;
                        csr_resp_valid <= 1'b0;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign eff_rm         = (inst_rm == RM_DYN) ? frm_q : inst_rm;
    assign eff_rm_illegal = rm_is_reserved(eff_rm);
    assign fflags         = fflags_q;
    assign frm            = frm_q;

endmodule

// File: tb/tb_riscv32f_csr_unit.sv
// Self-checking bench for riscv32f_csr_unit: vector table plus handshake/reset sequences.
module tb_riscv32f_csr_unit;

    localparam logic [2:0] RST_FRM = 3'b000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        csr_req_valid = 1'b0;
    logic        csr_req_ready;
    logic [11:0] csr_req_addr = 12'h0;
    logic [1:0]  csr_req_op = 2'b11;
    logic [31:0] csr_req_data = 32'h0;
    logic        csr_resp_valid;
    logic        csr_resp_ready = 1'b1;
    logic [31:0] csr_resp_data;
    logic        csr_resp_error;
    logic        fpu_flags_valid = 1'b0;
    logic [4:0]  fpu_flags = 5'h0;
    logic [2:0]  inst_rm = 3'b000;
    logic [2:0]  eff_rm;
    logic        eff_rm_illegal;
    logic [4:0]  fflags;
    logic [2:0]  frm;

    riscv32f_csr_unit #(.RESET_FRM(RST_FRM)) dut (
        .clk            (clk),
        .rst            (rst),
        .csr_req_valid  (csr_req_valid),
        .csr_req_ready  (csr_req_ready),
        .csr_req_addr   (csr_req_addr),
        .csr_req_op     (csr_req_op),
        .csr_req_data   (csr_req_data),
        .csr_resp_valid (csr_resp_valid),
        .csr_resp_ready (csr_resp_ready),
        .csr_resp_data  (csr_resp_data),
        .csr_resp_error (csr_resp_error),
        .fpu_flags_valid(fpu_flags_valid),
        .fpu_flags      (fpu_flags),
        .inst_rm        (inst_rm),
        .eff_rm         (eff_rm),
        .eff_rm_illegal (eff_rm_illegal),
        .fflags         (fflags),
        .frm            (frm)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [11:0] addr;
        logic [1:0]  op;
        logic [31:0] data;
        logic        fv;
        logic [4:0]  ff;
        logic [31:0] rdata;
        logic        err;
        logic [4:0]  xff;
        logic [2:0]  xfrm;
    } vec_t;

    typedef struct packed {
        logic [31:0] data;
        logic        err;
    } resp_t;

    vec_t  vecs[12];
    resp_t sb[$];
    int    n_cmp = 0;
    int    n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Response scoreboard: every completed handshake must match the oldest expectation.
    always @(negedge clk) begin
        if (!rst && csr_resp_valid && csr_resp_ready) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL resp_unexpected: got %h with empty scoreboard", csr_resp_data);
            end else begin
                resp_t e;
                e = sb.pop_front();
                chk("resp_data", csr_resp_data, e.data);
                chk("resp_err", {31'h0, csr_resp_error}, {31'h0, e.err});
            end
        end
    end

    task automatic check_rm(input logic [2:0] frm_exp);
        for (int r = 0; r < 8; r++) begin
            logic [2:0] er;
            inst_rm = 3'(r);
            #1;
            er = (r == 7) ? frm_exp : 3'(r);
            chk($sformatf("eff_rm_%0d", r), {29'h0, eff_rm}, {29'h0, er});
            chk($sformatf("rm_illegal_%0d", r), {31'h0, eff_rm_illegal},
                {31'h0, (er == 3'b101 || er == 3'b110 || er == 3'b111)});
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        //            addr    op     data          fv    ff      rdata   err   xff     xfrm
        vecs[0]  = '{12'h003, 2'b00, 32'h000000E5, 1'b0, 5'h00, 32'h00, 1'b0, 5'h05, 3'd7};
        vecs[1]  = '{12'h002, 2'b11, 32'h000000FF, 1'b0, 5'h00, 32'h07, 1'b0, 5'h05, 3'd7};
        vecs[2]  = '{12'h001, 2'b10, 32'h00000004, 1'b0, 5'h00, 32'h05, 1'b0, 5'h01, 3'd7};
        vecs[3]  = '{12'h001, 2'b01, 32'h00000010, 1'b1, 5'h04, 32'h01, 1'b0, 5'h15, 3'd7};
        vecs[4]  = '{12'h004, 2'b00, 32'hFFFFFFFF, 1'b0, 5'h00, 32'h00, 1'b1, 5'h15, 3'd7};
        vecs[5]  = '{12'h002, 2'b00, 32'hFFFFFFFA, 1'b0, 5'h00, 32'h07, 1'b0, 5'h15, 3'd2};
        vecs[6]  = '{12'h003, 2'b10, 32'h00000041, 1'b0, 5'h00, 32'h55, 1'b0, 5'h14, 3'd0};
        vecs[7]  = '{12'h002, 2'b01, 32'h00000005, 1'b0, 5'h00, 32'h00, 1'b0, 5'h14, 3'd5};
        vecs[8]  = '{12'h001, 2'b00, 32'h00000000, 1'b1, 5'h03, 32'h14, 1'b0, 5'h03, 3'd5};
        vecs[9]  = '{12'h003, 2'b11, 32'h00000000, 1'b0, 5'h00, 32'hA3, 1'b0, 5'h03, 3'd5};
        vecs[10] = '{12'h000, 2'b11, 32'h00000000, 1'b1, 5'h08, 32'h00, 1'b1, 5'h0B, 3'd5};
        vecs[11] = '{12'h003, 2'b00, 32'h00000100, 1'b0, 5'h00, 32'hAB, 1'b0, 5'h00, 3'd0};

        // Reset state
        #1;
        chk("rst_resp_valid", {31'h0, csr_resp_valid}, 32'h0);
        chk("rst_resp_data", csr_resp_data, 32'h0);
        chk("rst_resp_err", {31'h0, csr_resp_error}, 32'h0);
        chk("rst_fflags", {27'h0, fflags}, 32'h0);
        chk("rst_frm", {29'h0, frm}, {29'h0, RST_FRM});
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        chk("rst_req_ready", {31'h0, csr_req_ready}, 32'h1);

        // Table-driven single accesses
        for (int i = 0; i < 12; i++) begin
            @(posedge clk);
            #1;
            csr_req_valid   = 1'b1;
            csr_req_addr    = vecs[i].addr;
            csr_req_op      = vecs[i].op;
            csr_req_data    = vecs[i].data;
            fpu_flags_valid = vecs[i].fv;
            fpu_flags       = vecs[i].ff;
            sb.push_back('{data: vecs[i].rdata, err: vecs[i].err});
            @(posedge clk);
            #1;
            csr_req_valid   = 1'b0;
            fpu_flags_valid = 1'b0;
            fpu_flags       = 5'h0;
            chk($sformatf("v%0d_fflags", i), {27'h0, fflags}, {27'h0, vecs[i].xff});
            chk($sformatf("v%0d_frm", i), {29'h0, frm}, {29'h0, vecs[i].xfrm});
            if (i == 0) check_rm(3'd7);
        end
        check_rm(3'd0);

        // Back-to-back requests, one response per cycle
        @(posedge clk);
        #1;
        csr_resp_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            csr_req_valid = 1'b1;
            csr_req_addr  = 12'h001;
            case (k)
                0: begin csr_req_op = 2'b00; csr_req_data = 32'h01; sb.push_back('{data: 32'h0, err: 1'b0}); end
                1: begin csr_req_op = 2'b01; csr_req_data = 32'h02; sb.push_back('{data: 32'h1, err: 1'b0}); end
                2: begin csr_req_op = 2'b01; csr_req_data = 32'h04; sb.push_back('{data: 32'h3, err: 1'b0}); end
                default: begin csr_req_op = 2'b11; csr_req_data = 32'h0; sb.push_back('{data: 32'h7, err: 1'b0}); end
            endcase
            chk($sformatf("b2b_req_ready_%0d", k), {31'h0, csr_req_ready}, 32'h1);
            @(posedge clk);
            #1;
        end
        csr_req_valid = 1'b0;
        chk("b2b_fflags", {27'h0, fflags}, 32'h07);

        // Consumer stall for three cycles
        @(posedge clk);
        #1;
        csr_resp_ready = 1'b0;
        csr_req_valid  = 1'b1;
        csr_req_addr   = 12'h003;
        csr_req_op     = 2'b11;
        sb.push_back('{data: 32'h07, err: 1'b0});
        @(posedge clk);
        #1;
        csr_req_addr = 12'h001;
        csr_req_op   = 2'b00;
        csr_req_data = 32'h0;
        for (int s = 0; s < 3; s++) begin
            chk($sformatf("stall_valid_%0d", s), {31'h0, csr_resp_valid}, 32'h1);
            chk($sformatf("stall_data_%0d", s), csr_resp_data, 32'h07);
            chk($sformatf("stall_req_ready_%0d", s), {31'h0, csr_req_ready}, 32'h0);
            chk($sformatf("stall_fflags_%0d", s), {27'h0, fflags}, 32'h07);
            @(posedge clk);
            #1;
        end
        csr_resp_ready = 1'b1;
        sb.push_back('{data: 32'h07, err: 1'b0});
        @(posedge clk);
        #1;
        csr_req_valid = 1'b0;
        chk("stall_fflags_after", {27'h0, fflags}, 32'h0);
        @(posedge clk);
        #1;

        // Reset while a response is pending
        csr_resp_ready = 1'b0;
        csr_req_valid  = 1'b1;
        csr_req_addr   = 12'h003;
        csr_req_op     = 2'b00;
        csr_req_data   = 32'h000000FF;
        @(posedge clk);
        #1;
        csr_req_valid = 1'b0;
        chk("prerst_valid", {31'h0, csr_resp_valid}, 32'h1);
        chk("prerst_frm", {29'h0, frm}, 32'h7);
        chk("prerst_fflags", {27'h0, fflags}, 32'h1F);
        rst = 1'b1;
        #1;
        chk("midrst_valid", {31'h0, csr_resp_valid}, 32'h0);
        chk("midrst_data", csr_resp_data, 32'h0);
        chk("midrst_err", {31'h0, csr_resp_error}, 32'h0);
        chk("midrst_frm", {29'h0, frm}, {29'h0, RST_FRM});
        chk("midrst_fflags", {27'h0, fflags}, 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("postrst_req_ready", {31'h0, csr_req_ready}, 32'h1);
        csr_resp_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("postrst_valid", {31'h0, csr_resp_valid}, 32'h0);
        chk("sb_drained", sb.size(), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
